// File: rtl/riscv_dp_fetch_buf.sv
// Fetch stage with an MP_DEPTH-entry prefetch queue; up to MP_DEPTH requests outstanding.
// Head visible 2 cycles after a grant with 1-cycle memory; decode stalls via iready, and requests throttle on queue credit.
module riscv_dp_fetch_buf #(
    parameter int                     MP_PC_WIDTH    = 32,
    parameter int                     MP_INSTR_WIDTH = 32,
    parameter int                     MP_DEPTH       = 4,
    parameter logic [MP_PC_WIDTH-1:0] MP_RESET_PC    = '0
) (
    input  logic                      iclk,
    input  logic                      irst_n,
    output logic                      oimem_req,
    output logic [MP_PC_WIDTH-1:0]    oimem_addr,
    input  logic                      iimem_gnt,
    input  logic                      iimem_rvalid,
    input  logic [MP_INSTR_WIDTH-1:0] iimem_rdata,
    input  logic                      iredirect,
    input  logic [MP_PC_WIDTH-1:0]    iredirect_pc,
    output logic                      ovalid,
    output logic [MP_INSTR_WIDTH-1:0] oinstr,
    output logic [MP_PC_WIDTH-1:0]    opc,
    output logic [MP_PC_WIDTH-1:0]    opc_plus4,
    input  logic                      iready
);
    localparam int AW = $clog2(MP_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [MP_PC_WIDTH-1:0] PC_STEP = MP_PC_WIDTH'(4);
    localparam logic [CW:0]            DEPTH_C = (CW+1)'(MP_DEPTH);

    typedef struct packed {
        logic [MP_INSTR_WIDTH-1:0] instr;
        logic [MP_PC_WIDTH-1:0]    pc;
    } entry_t;

    entry_t                 mem_q [MP_DEPTH];
    entry_t                 head;
    logic [MP_PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [MP_PC_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [CW-1:0]          drop_q, drop_d;
    logic [AW-1:0]          wptr_q, wptr_d;
    logic [AW-1:0]          rptr_q, rptr_d;
    logic [CW:0]            credit;
    logic                   accept, rsp_drop, rsp_keep, push, pop;

    // Credit counts queued plus outstanding words, so a kept response always has a slot.
    assign credit    = {1'b0, count_q} + {1'b0, inflight_q};
    assign oimem_req = ~iredirect && (credit < DEPTH_C);
    assign oimem_addr = fetch_pc_q;
    assign accept    = oimem_req && iimem_gnt;
    assign rsp_drop  = iimem_rvalid && (drop_q != '0);
    assign rsp_keep  = iimem_rvalid && (drop_q == '0) && (inflight_q != '0);
    assign push      = rsp_keep && !iredirect;
    assign ovalid    = (count_q != '0);
    assign pop       = ovalid && iready && !iredirect;

    assign head      = mem_q[rptr_q];
    assign oinstr    = ovalid ? head.instr : '0;
    assign opc       = ovalid ? head.pc : '0;
    assign opc_plus4 = opc + PC_STEP;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        if (iredirect) begin
            fetch_pc_d = iredirect_pc;
            rsp_pc_d   = iredirect_pc;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            inflight_d = '0;
            // Everything still outstanding becomes stale, minus a response retired this cycle.
            drop_d     = drop_q + inflight_q - CW'(rsp_drop | rsp_keep);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                wptr_d   = wptr_q + AW'(1);
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d    = count_q + CW'(push) - CW'(pop);
            inflight_d = inflight_q + CW'(accept) - CW'(push);
            drop_d     = drop_q - CW'(rsp_drop);
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            fetch_pc_q <= MP_RESET_PC;
            rsp_pc_q   <= MP_RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
        end
    end

    always_ff @(posedge iclk) begin
        if (push) begin
            mem_q[wptr_q] <= '{instr: iimem_rdata, pc: rsp_pc_q};
        end
    end
endmodule

// File: tb/tb_riscv_dp_fetch_buf.sv
// Directed bench for riscv_dp_fetch_buf: in-order memory model with configurable latency
// and a PC scoreboard on every decode pop.
module tb_riscv_dp_fetch_buf;
    localparam int D = 4;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        oimem_req;
    logic [31:0] oimem_addr;
    logic        iimem_gnt;
    logic        iimem_rvalid;
    logic [31:0] iimem_rdata;
    logic        iredirect;
    logic [31:0] iredirect_pc;
    logic        ovalid;
    logic [31:0] oinstr;
    logic [31:0] opc;
    logic [31:0] opc_plus4;
    logic        iready;

    always #5 iclk = ~iclk;

    riscv_dp_fetch_buf #(
        .MP_PC_WIDTH(32), .MP_INSTR_WIDTH(32), .MP_DEPTH(D), .MP_RESET_PC(32'h0)
    ) dut (
        .iclk(iclk), .irst_n(irst_n),
        .oimem_req(oimem_req), .oimem_addr(oimem_addr), .iimem_gnt(iimem_gnt),
        .iimem_rvalid(iimem_rvalid), .iimem_rdata(iimem_rdata),
        .iredirect(iredirect), .iredirect_pc(iredirect_pc),
        .ovalid(ovalid), .oinstr(oinstr), .opc(opc), .opc_plus4(opc_plus4),
        .iready(iready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          cyc = 0;
    int          pops = 0;
    int          grants = 0;
    bit          rnd_stall = 0;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: observe settled outputs, then step the memory model past the edge.
    task automatic cycle();
        logic        acc;
        logic [31:0] a;
        #1;
        acc = oimem_req && iimem_gnt;
        a   = oimem_addr;
        if (ovalid && iready && !iredirect) begin
            chk("pop_pc", opc, exp_pc);
            chk("pop_instr", oinstr, ~exp_pc);
            chk("pop_plus4", opc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        chk("credit_bound", 32'(int'(dut.count_q) + int'(dut.inflight_q) <= D), 32'd1);
        if (acc) grants++;
        @(posedge iclk);
        #1;
        cyc++;
        if (acc) pq.push_back('{a, cyc - 1 + lat});
        iimem_rvalid = 1'b0;
        iimem_rdata  = '0;
        if (pq.size() > 0 && pq[0].due <= cyc && !(rnd_stall && $urandom_range(3) == 0)) begin
            iimem_rvalid = 1'b1;
            iimem_rdata  = ~pq[0].addr;
            void'(pq.pop_front());
        end
    endtask

    task automatic reset_assert();
        irst_n       = 1'b0;
        iredirect    = 1'b0;
        iimem_rvalid = 1'b0;
        iimem_rdata  = '0;
        pq.delete();
    endtask

    task automatic reset_release();
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        exp_pc = 32'h0;
        pops   = 0;
        grants = 0;
        cyc    = 0;
    endtask

    initial begin
        int          n;
        int          pops_before;
        logic [31:0] r;

        irst_n = 1'b0; iimem_gnt = 1'b0; iimem_rvalid = 1'b0; iimem_rdata = '0;
        iredirect = 1'b0; iredirect_pc = '0; iready = 1'b0; exp_pc = 32'h0;
        repeat (2) @(posedge iclk);
        #1;
        chk("rst_ovalid", ovalid, 32'd0);
        chk("rst_addr", oimem_addr, 32'h0);
        chk("rst_req", oimem_req, 32'd1);
        chk("rst_instr", oinstr, 32'h0);
        chk("rst_pc", opc, 32'h0);

        // Streaming with a 1-cycle memory: first valid two cycles after the first grant.
        irst_n = 1'b1; iimem_gnt = 1'b1; iready = 1'b1; lat = 1;
        cycle();
        chk("lat_c1_ovalid", ovalid, 32'd0);
        cycle();
        chk("lat_c2_ovalid", ovalid, 32'd1);
        chk("lat_c2_pc", opc, 32'h0);
        repeat (12) cycle();
        chk("stream_pops", pops, 32'd12);
        chk("stream_next_pc", exp_pc, 32'd48);

        // Decode stall fills the queue; requests stop at MP_DEPTH.
        reset_assert();
        reset_release();
        iready = 1'b0;
        repeat (8) cycle();
        chk("full_grants", grants, 32'd4);
        chk("full_req", oimem_req, 32'd0);
        chk("full_ovalid", ovalid, 32'd1);
        chk("full_count", 32'(dut.count_q), 32'd4);
        chk("full_head_pc", opc, 32'h0);

        // Asynchronous reset with a full queue.
        #2;
        reset_assert();
        #1;
        chk("async_rst_ovalid", ovalid, 32'd0);
        chk("async_rst_addr", oimem_addr, 32'h0);
        reset_release();
        chk("restart_addr", oimem_addr, 32'h0);
        chk("restart_req", oimem_req, 32'd1);
        iready = 1'b0;
        repeat (8) cycle();
        chk("refill_grants", grants, 32'd4);
        iready = 1'b1;
        repeat (10) cycle();
        chk("drain_pops", pops, 32'd10);
        chk("resume_req", 32'(grants > 4), 32'd1);

        // Redirect with three requests outstanding on a 3-cycle memory.
        reset_assert();
        reset_release();
        lat = 3;
        repeat (3) cycle();
        chk("rd3_grants", grants, 32'd3);
        iredirect = 1'b1; iredirect_pc = 32'h100; exp_pc = 32'h100;
        #1;
        chk("rd3_req_blocked", oimem_req, 32'd0);
        cycle();
        iredirect = 1'b0;
        #1;
        chk("rd3_req_after", oimem_req, 32'd1);
        chk("rd3_addr_after", oimem_addr, 32'h100);
        n = 0;
        while (!ovalid && n < 20) begin
            cycle();
            n++;
        end
        chk("rd3_seen", ovalid, 32'd1);
        chk("rd3_first_pc", opc, 32'h100);
        chk("rd3_first_plus4", opc_plus4, 32'h104);
        repeat (6) cycle();
        chk("rd3_drop_zero", 32'(dut.drop_q), 32'd0);

        // Redirect coinciding with a response and a pop, then a second redirect.
        reset_assert();
        reset_release();
        lat = 2;
        repeat (8) cycle();
        chk("rd2_rsp_same", iimem_rvalid, 32'd1);
        chk("rd2_ovalid_same", ovalid, 32'd1);
        iredirect = 1'b1; iredirect_pc = 32'h300; exp_pc = 32'h300;
        cycle();
        iredirect_pc = 32'h200; exp_pc = 32'h200;
        cycle();
        iredirect = 1'b0;
        pops_before = pops;
        repeat (12) cycle();
        chk("rd2_drop_zero", 32'(dut.drop_q), 32'd0);
        chk("rd2_progress", 32'(pops - pops_before >= 8), 32'd1);

        // Random stalls, latencies and redirects against the scoreboard.
        reset_assert();
        reset_release();
        rnd_stall = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            iimem_gnt = ($urandom_range(3) != 0);
            iready    = ($urandom_range(3) != 0);
            lat       = $urandom_range(3, 1);
            if ($urandom_range(63) == 0) begin
                r = $urandom;
                r[1:0] = 2'b00;
                iredirect = 1'b1; iredirect_pc = r; exp_pc = r;
            end else begin
                iredirect = 1'b0;
            end
            cycle();
        end
        iredirect = 1'b0;
        chk("rand_progress", 32'(pops > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
